// File: rtl/isr_pkg.sv
// Shared types, default parameters and the vector-address helper for the interrupt sequencer.
// Optional build macro INT_ROUND_ROBIN_EN selects round-robin arbitration.
package isr_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StActive  = 2'd1,
    StHoldoff = 2'd2
  } isr_state_e;

  localparam int unsigned NUM_SRC_DEF    = 4;
  localparam int unsigned ISR_BASE_DEF   = 32'hF00;
  localparam int unsigned VEC_STRIDE_DEF = 16;
  localparam int unsigned ID_W           = 3;

  // Full-width vector address; the caller truncates to its PC width.
  function automatic logic [31:0] isr_vector(input int unsigned base,
                                             input int unsigned stride,
                                             input int unsigned idx);
    return 32'(base + idx * stride);
  endfunction

endpackage

// File: rtl/isr_arbiter.sv
// Picks one eligible interrupt source: lowest index by default, or round-robin from rr_ptr
// when INT_ROUND_ROBIN_EN is defined.
module isr_arbiter
  import isr_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0] eligible,
`ifdef INT_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]    rr_ptr,
`endif
  output logic [NUM_SRC-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    int unsigned j;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
`ifdef INT_ROUND_ROBIN_EN
      j = (32'(rr_ptr) + k) % NUM_SRC;
`else
      j = k;
`endif
      if (!found && eligible[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Takes a pending interrupt into a single-level handler by flushing and redirecting the PC,
// restores the saved PC on return, then enforces a hold-off. Macro: INT_ROUND_ROBIN_EN.
module interrupt_sequencer
  import isr_pkg::*;
#(
  parameter int unsigned NUM_SRC     = NUM_SRC_DEF,
  parameter int unsigned PC_W        = 12,
  parameter int unsigned ISR_BASE    = ISR_BASE_DEF,
  parameter int unsigned VEC_STRIDE  = VEC_STRIDE_DEF,
  parameter int unsigned HOLDOFF_CYC = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_SRC-1:0] int_req,
  input  logic [NUM_SRC-1:0] int_en,
  input  logic               global_ie,
  input  logic [PC_W-1:0]    id_pc,
  input  logic               id_valid,
  input  logic               pipe_busy,
  input  logic               redirect_pending,
  input  logic               isr_ret,
  output logic               ISR_PC_flush,
  output logic               ISR_pipe_flush,
  output logic               isr_redirect_en,
  output logic [PC_W-1:0]    isr_redirect_pc,
  output logic               in_isr,
  output logic [NUM_SRC-1:0] isr_ack,
  output logic [ID_W-1:0]    isr_id
);

  localparam int unsigned CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  isr_state_e         state_q;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [PC_W-1:0]    saved_pc_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [ID_W-1:0]    isr_id_q;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               pipe_clean;
  logic               take;
  logic               ret;

`ifdef INT_ROUND_ROBIN_EN
  logic [ID_W-1:0]    rr_ptr_q;
`endif

  assign eligible   = global_ie ? (pending_q & int_en) : '0;
  assign pipe_clean = !pipe_busy && !redirect_pending;
  assign take       = (state_q == StIdle) && (eligible != '0) && id_valid && pipe_clean;
  assign ret        = (state_q == StActive) && isr_ret && pipe_clean;

  isr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arbiter (
    .eligible  (eligible),
`ifdef INT_ROUND_ROBIN_EN
    .rr_ptr    (rr_ptr_q),
`endif
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pulse outputs are combinational so the front end is redirected in the decision cycle.
  always_comb begin
    ISR_PC_flush    = take || ret;
    ISR_pipe_flush  = take || ret;
    isr_redirect_en = take || ret;
    isr_ack         = take ? grant : '0;
    isr_redirect_pc = '0;
    if (take) begin
      isr_redirect_pc = PC_W'(isr_vector(ISR_BASE, VEC_STRIDE, 32'(grant_idx)));
    end else if (ret) begin
      isr_redirect_pc = saved_pc_q;
    end
  end

  assign in_isr = (state_q == StActive);
  assign isr_id = isr_id_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      req_q      <= '0;
      pending_q  <= '0;
      saved_pc_q <= '0;
      hold_cnt_q <= '0;
      isr_id_q   <= '0;
`ifdef INT_ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      req_q     <= int_req;
      // A new edge in the ack cycle wins over the clear.
      pending_q <= (pending_q & ~isr_ack) | (int_req & ~req_q);
      unique case (state_q)
        StIdle: begin
          if (take) begin
            state_q    <= StActive;
            saved_pc_q <= id_pc;
            isr_id_q   <= grant_idx;
`ifdef INT_ROUND_ROBIN_EN
            rr_ptr_q   <= (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
`endif
          end
        end
        StActive: begin
          if (ret) begin
            state_q    <= (HOLDOFF_CYC == 0) ? StIdle : StHoldoff;
            hold_cnt_q <= '0;
          end
        end
        StHoldoff: begin
          // Only cycles where the pipe actually advances count toward the hold-off.
          if (id_valid && !pipe_busy) begin
            if (hold_cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
              state_q    <= StIdle;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
